// File: rtl/mult_booth_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states, Booth
// step codes and the iteration count.
package mult_booth_seq_pkg;

    localparam int MULT_ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {q[0], q_m1}.
    function automatic booth_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   booth_decode = BOOTH_ADD;
            2'b10:   booth_decode = BOOTH_SUB;
            default: booth_decode = BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_booth_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead blocks with block-level
// generate/propagate chained for the carries between blocks.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  bg;
    logic [7:0]  bp;
    logic [8:0]  bc;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar blk = 0; blk < 8; blk++) begin : g_blk
        localparam int B = blk * 4;
        assign bg[blk] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign bp[blk] = &p[B+3:B];
    end

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        bc    = '0;
        c     = '0;
        bc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            bc[k+1] = bg[k] | (bp[k] & bc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
    end

    assign sum  = p ^ c;
    assign cout = bc[8];

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential 32x32 signed radix-2 Booth multiplier: one cla32 add and one
// arithmetic shift per cycle, low product word plus signed-overflow flag.
module mult_booth_seq
    import mult_booth_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH+1:0] p;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   count;

    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     acc_nxt;
    logic [2*WIDTH+1:0] p_nxt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cin;
    logic               c32;
    logic               last;
    booth_t             op;

    assign acc  = p[2*WIDTH+1:WIDTH+1];
    assign op   = booth_decode(p[1], p[0]);
    assign last = (count == CNT_W'(MULT_ITERS - 1));

    always_comb begin
        addend = '0;
        cin    = 1'b0;
        case (op)
            BOOTH_ADD: addend = m;
            BOOTH_SUB: begin
                addend = ~m;
                cin    = 1'b1;
            end
            default: ;
        endcase
    end

    cla32 u_cla (
        .a    (acc[WIDTH-1:0]),
        .b    (addend),
        .cin  (cin),
        .sum  (sum),
        .cout (c32)
    );

    // The top acc bit absorbs the sign extension of the addend, so the 33-bit acc never wraps.
    assign acc_nxt = {acc[WIDTH] ^ addend[WIDTH-1] ^ c32, sum};
    assign p_nxt   = {acc_nxt[WIDTH], acc_nxt, p[WIDTH:1]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_MULT) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   state_nxt = last ? S_DONE : S_RUN;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state != S_IDLE);
        data_resultRDY = (state == S_DONE);
    end

    // Results are captured from the final shifted value so they are already valid in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            p              <= '0;
            m              <= '0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            m     <= data_operandA;
            p     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
            count <= '0;
        end else if (state == S_RUN) begin
            p     <= p_nxt;
            count <= count + CNT_W'(1);
            if (last) begin
                data_result    <= p_nxt[WIDTH:1];
                data_exception <= ~(&p_nxt[2*WIDTH:WIDTH] | ~|p_nxt[2*WIDTH:WIDTH]);
            end
        end
    end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed and seeded-random checks of mult_booth_seq: latency, overflow flag,
// abort/restart, reset priority.
module tb_mult_booth_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mult_booth_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns 1ns after the sampling edge (cycle 1 begins).
    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        data_operandA = x;
        data_operandB = y;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Returns at the negedge of the RDY cycle, or with cyc = -1 after 40 cycles.
    task automatic wait_rdy(output int cyc, output int busy_low);
        cyc      = -1;
        busy_low = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (busy !== 1'b1) busy_low++;
            if (data_resultRDY === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ee);
        int cyc;
        int bl;
        start_op(x, y);
        wait_rdy(cyc, bl);
        check({tag, " rdy_cycle"}, 32'(cyc), 32'd33);
        check({tag, " busy"}, 32'(bl), 32'd0);
        check({tag, " result"}, data_result, er);
        check({tag, " exc"}, {31'b0, data_exception}, {31'b0, ee});
        @(negedge clock);
        check({tag, " rdy_pulse"}, {31'b0, data_resultRDY}, 32'd0);
        check({tag, " held"}, data_result, er);
        check({tag, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          cyc;
        int          bl;
        int          rdy_seen;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] er;
        logic        ee;
        longint      prod;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
        check("reset result", data_result, 32'd0);
        check("reset exc", {31'b0, data_exception}, 32'd0);

        run_op("7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("min x -1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("2^16 x 2^16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("ffff x 10001", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b1);
        run_op("-1 x -1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("0 x max", 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0);
        run_op("min x 1", 32'h8000_0000, 32'h1, 32'h8000_0000, 1'b0);
        run_op("1 x min", 32'h1, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Abort: 5x5 restarted by 6x7 in cycle 10, then restart inside the DONE cycle.
        start_op(32'd5, 32'd5);
        rdy_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("abort no early rdy", 32'(rdy_seen), 32'd0);
        start_op(32'd6, 32'd7);
        wait_rdy(cyc, bl);
        check("abort rdy_cycle", 32'(cyc), 32'd33);
        check("abort result", data_result, 32'd42);
        check("abort exc", {31'b0, data_exception}, 32'd0);
        start_op(32'hFFFF_FFF7, 32'd11);
        wait_rdy(cyc, bl);
        check("done restart rdy_cycle", 32'(cyc), 32'd33);
        check("done restart result", data_result, 32'hFFFF_FF9D);

        // Reset in cycle 15 of an op.
        @(negedge clock);
        start_op(32'h0000_1234, 32'h0000_5678);
        for (int c = 1; c <= 15; c++) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset result", data_result, 32'd0);
        check("midreset exc", {31'b0, data_exception}, 32'd0);
        rdy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("midreset no rdy", 32'(rdy_seen), 32'd0);
        run_op("3x4", 32'd3, 32'd4, 32'd12, 1'b0);

        // Reset wins over a simultaneous start.
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        @(negedge clock);
        check("reset beats start busy", {31'b0, busy}, 32'd0);
        check("reset beats start result", data_result, 32'd0);

        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 1) x = x >>> 16;
            if (i % 4 == 2) y = {{16{y[15]}}, y[15:0]};
            prod = longint'($signed(x)) * longint'($signed(y));
            er   = prod[31:0];
            ee   = (prod != longint'($signed(er)));
            run_op($sformatf("rand%0d", i), x, y, er, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
